// File: rtl/fetch_unit.sv
// Program-counter / fetch control in front of a 1-cycle registered instruction memory.
// Tracks read latency, squashes wrong-path words on redirect, holds on stall, latches fetch faults.
module fetch_unit #(
  parameter int unsigned PC_WIDTH   = 6,
  parameter int unsigned RESET_PC   = 0,
  parameter int unsigned IMEM_WORDS = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                hold,
  input  logic                redirect,
  input  logic [PC_WIDTH-1:0] target,
  output logic [PC_WIDTH-1:0] pc,
  output logic [PC_WIDTH-1:0] ins_pc,
  output logic                ins_valid,
  output logic                fault
);

  localparam int unsigned IMEM_BYTES = 4 * IMEM_WORDS;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FAULT = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d, ins_pc_d;
  logic                ins_valid_d, fault_d;
  logic                target_legal;

  assign target_legal = (target[1:0] == 2'b00) && (32'(target) < IMEM_BYTES);

  // During a stall the memory re-reads the word already on its output.
  assign pc = (hold && ins_valid) ? ins_pc : pc_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      pc_q      <= PC_WIDTH'(RESET_PC);
      ins_pc    <= '0;
      ins_valid <= 1'b0;
      fault     <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ins_pc    <= ins_pc_d;
      ins_valid <= ins_valid_d;
      fault     <= fault_d;
    end
  end

  // Next-state: fault detection > pause > hold > redirect > sequential fetch.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    ins_pc_d    = ins_pc;
    ins_valid_d = ins_valid;
    fault_d     = fault;
    case (state_q)
      IDLE: begin
        ins_valid_d = 1'b0;
        if (en) state_d = RUN;
      end
      RUN: begin
        if (redirect && !target_legal) begin
          state_d     = FAULT;
          fault_d     = 1'b1;
          ins_valid_d = 1'b0;
        end else if (!en) begin
          state_d     = IDLE;
          ins_valid_d = 1'b0;
        end else if (!hold) begin
          if (redirect) begin
            pc_d        = target;
            ins_valid_d = 1'b0;
          end else begin
            pc_d        = pc_q + PC_WIDTH'(4);
            ins_pc_d    = pc_q;
            ins_valid_d = 1'b1;
          end
        end
      end
      FAULT: begin
        ins_valid_d = 1'b0;
      end
      default: begin
        state_d     = IDLE;
        ins_valid_d = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: per-cycle behavioural model plus directed literal checks,
// with a second 7-bit instance for the out-of-range-target boundary.
module tb_fetch_unit;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0, hold = 1'b0, redirect = 1'b0;
  logic [5:0] target = '0;
  logic [5:0] pc, ins_pc;
  logic       ins_valid, fault;

  logic       en2 = 1'b0, redirect2 = 1'b0;
  logic [6:0] target2 = '0;
  logic [6:0] pc2, ins_pc2;
  logic       ins_valid2, fault2;

  int errors = 0;
  int checks = 0;

  // Model: fetch pointer, last delivered word, delivery flag, run/fault flags.
  int m_ptr = 0, m_ins = 0, m_valid = 0, m_run = 0, m_fault = 0;

  fetch_unit #(.PC_WIDTH(6), .RESET_PC(0), .IMEM_WORDS(16)) dut (
    .clk(clk), .rst(rst), .en(en), .hold(hold), .redirect(redirect), .target(target),
    .pc(pc), .ins_pc(ins_pc), .ins_valid(ins_valid), .fault(fault)
  );

  fetch_unit #(.PC_WIDTH(7), .RESET_PC(0), .IMEM_WORDS(16)) dut2 (
    .clk(clk), .rst(rst), .en(en2), .hold(1'b0), .redirect(redirect2), .target(target2),
    .pc(pc2), .ins_pc(ins_pc2), .ins_valid(ins_valid2), .fault(fault2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  function automatic void model_reset();
    m_ptr = 0; m_ins = 0; m_valid = 0; m_run = 0; m_fault = 0;
  endfunction

  // One clock edge of the fetch stage, expressed as prioritised rules on plain integers.
  function automatic void model_step();
    bit illegal;
    illegal = (int'(target) % 4 != 0) || (int'(target) >= 64);
    if (m_fault != 0) begin
      m_valid = 0;
    end else if (m_run != 0 && redirect && illegal) begin
      m_fault = 1; m_run = 0; m_valid = 0;
    end else if (m_run == 0) begin
      m_run = en ? 1 : 0; m_valid = 0;
    end else if (!en) begin
      m_run = 0; m_valid = 0;
    end else if (hold) begin
      // stall: nothing moves
    end else if (redirect) begin
      m_ptr = int'(target); m_valid = 0;
    end else begin
      m_ins = m_ptr; m_valid = 1; m_ptr = (m_ptr + 4) % 64;
    end
  endfunction

  always @(posedge rst) model_reset();

  always @(posedge clk) begin
    if (!rst) model_step();
    #1;
    if (!rst) begin
      chk("model_pc", int'(pc), (hold && m_valid != 0) ? m_ins : m_ptr);
      chk("model_valid", int'(ins_valid), m_valid);
      chk("model_fault", int'(fault), m_fault);
      if (m_valid != 0) chk("model_ins_pc", int'(ins_pc), m_ins);
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    #12 rst = 1'b0;
    tick();
    chk("rst_pc", int'(pc), 0);
    chk("rst_ins_pc", int'(ins_pc), 0);
    chk("rst_valid", int'(ins_valid), 0);
    chk("rst_fault", int'(fault), 0);

    // Start-up latency and sequential fetch.
    en = 1'b1;
    tick(); chk("t1_first_valid", int'(ins_valid), 0); chk("t1_first_pc", int'(pc), 0);
    tick(); chk("t1_pc4", int'(pc), 4); chk("t1_ins0", int'(ins_pc), 0); chk("t1_v", int'(ins_valid), 1);
    tick(); chk("t1_pc8", int'(pc), 8); chk("t1_ins4", int'(ins_pc), 4);

    // Redirect while ins_pc=4.
    redirect = 1'b1; target = 6'h20;
    tick(); chk("t4_squash", int'(ins_valid), 0); chk("t4_pc", int'(pc), 32);
    redirect = 1'b0;
    tick(); chk("t4_ins", int'(ins_pc), 32); chk("t4_v", int'(ins_valid), 1);

    // Wrap through 60 -> 0.
    repeat (7) tick();
    chk("t2_ins60", int'(ins_pc), 60); chk("t2_pc_wrap", int'(pc), 0);
    tick(); chk("t2_ins_wrap", int'(ins_pc), 0); chk("t2_v", int'(ins_valid), 1);
    tick(); tick(); chk("t3_ins8", int'(ins_pc), 8);

    // Stall for three cycles on ins_pc=8.
    hold = 1'b1;
    #1 chk("t3_pc_mux", int'(pc), 8);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t3_hold_pc", int'(pc), 8);
      chk("t3_hold_ins", int'(ins_pc), 8);
      chk("t3_hold_v", int'(ins_valid), 1);
    end
    hold = 1'b0;
    #1 chk("t3_release_pc", int'(pc), 12);
    tick(); chk("t3_next_ins", int'(ins_pc), 12); chk("t3_next_pc", int'(pc), 16);

    // Pause two cycles, then resume at the retained pc.
    en = 1'b0;
    tick(); chk("t6_pause_v", int'(ins_valid), 0); chk("t6_pause_pc", int'(pc), 16);
    tick(); chk("t6_pause_pc2", int'(pc), 16);
    en = 1'b1;
    tick(); chk("t6_resume_v", int'(ins_valid), 0); chk("t6_resume_pc", int'(pc), 16);
    tick(); chk("t6_resume_ins", int'(ins_pc), 16); chk("t6_resume_v2", int'(ins_valid), 1);

    // Asynchronous reset between edges.
    #2 rst = 1'b1;
    #1 chk("t6_arst_pc", int'(pc), 0); chk("t6_arst_v", int'(ins_valid), 0); chk("t6_arst_f", int'(fault), 0);
    #1 rst = 1'b0;
    tick(); chk("t6_rerun_v", int'(ins_valid), 0);
    tick(); chk("t6_rerun_pc", int'(pc), 4); chk("t6_rerun_ins", int'(ins_pc), 0);

    // Misaligned redirect target faults and sticks.
    redirect = 1'b1; target = 6'h22;
    tick(); chk("t5_fault", int'(fault), 1); chk("t5_v", int'(ins_valid), 0); chk("t5_pc", int'(pc), 4);
    redirect = 1'b0;
    en = 1'b0; tick();
    hold = 1'b1; tick();
    en = 1'b1; hold = 1'b0; tick(); tick();
    chk("t5_sticky", int'(fault), 1); chk("t5_frozen", int'(pc), 4); chk("t5_v2", int'(ins_valid), 0);
    rst = 1'b1;
    #1 chk("t5_clear", int'(fault), 0);
    rst = 1'b0;

    // Wider instance: 0x3C is the last legal word, 0x40 is out of range.
    en2 = 1'b1;
    tick(); chk("w_first_v", int'(ins_valid2), 0);
    tick(); chk("w_pc4", int'(pc2), 4);
    redirect2 = 1'b1; target2 = 7'h3C;
    tick(); chk("w_legal_pc", int'(pc2), 60); chk("w_legal_f", int'(fault2), 0); chk("w_sq", int'(ins_valid2), 0);
    redirect2 = 1'b0;
    tick(); chk("w_ins3c", int'(ins_pc2), 60); chk("w_v", int'(ins_valid2), 1); chk("w_pc40", int'(pc2), 64);
    redirect2 = 1'b1; target2 = 7'h40;
    tick(); chk("w_fault", int'(fault2), 1); chk("w_fault_v", int'(ins_valid2), 0); chk("w_frozen", int'(pc2), 64);
    redirect2 = 1'b0; en2 = 1'b0;
    tick(); en2 = 1'b1; tick();
    chk("w_sticky", int'(fault2), 1); chk("w_frozen2", int'(pc2), 64);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
